agex_stage: RTL and testbench
=============================

// Module: agex_stage
// PURPOSE
//  Address-generation/execute stage sitting directly downstream of the decode stage: consumes one
//  decoded instruction per cycle, computes ALU results, load/store addresses, branch/jump outcomes
//  and MUL via an iterative shift-add unit, and registers the result into the AGEX->MEM latch.
//  Resolves control flow: a taken branch/jump raises br_clear so decode/fetch squash and redirect.
// PARAMETERS
//  MUL_BITS   4   multiplier bits consumed per busy cycle; must divide 32 (MUL_ITERS = 32/MUL_BITS)
// PORTS
//  clk            in   1        clock, all state on posedge
//  reset          in   1        asynchronous, active-low reset
//  in_valid       in   1        decode latch holds a real instruction (0 = bubble)
//  in_op          in   IOPBITS  internal opcode (ADD_I..CSRW_I, INVALID_I from define.vh)
//  in_pc          in   32       instruction PC
//  in_pcplus      in   32       PC+4
//  in_rs1         in   32       rs1 value
//  in_op2         in   32       rs2 value (R/S/B types) or sign-extended immediate (I/U/J types)
//  in_imm         in   32       S/B immediate (0 otherwise)
//  in_rd          in   5        destination register number
//  stall_out      out  1        upstream must hold every in_* stable while 1
//  br_clear       out  1        taken branch/jump in this cycle; squash younger instructions
//  br_target      out  32       redirect PC, valid when br_clear=1
//  out_valid      out  1        registered: AGEX latch holds a real instruction
//  out_op         out  IOPBITS  registered opcode
//  out_rd         out  5        registered destination
//  out_wr_reg     out  1        registered: write rd at WB (0 when rd==0)
//  out_result     out  32       registered ALU result / link value / product / memory address
//  out_wdata      out  32       registered store data (rs2), 0 for non-stores
// BEHAVIOUR
//  - Reset (reset=0, async): FSM=IDLE, all out_* = 0, stall_out=0, br_clear=0, multiplier regs cleared.
//  - Non-MUL ops: latency 1; output latch updated at the posedge of the cycle in_valid=1.
//    ADD/SUB/AND/OR/XOR/SLL/SRL/SRA/SLT/SLTU and I-forms use in_rs1 op in_op2; shifts use op2[4:0];
//    SLT/SLTI signed, SLTU/SLTIU unsigned; results mod 2^32.
//    LUI result=in_op2; AUIPC result=in_pc+in_op2; LW/SW result=in_rs1+in_op2 (LW) / in_rs1+in_imm (SW).
//    JAL: result=in_pcplus, target=in_pc+in_op2. JALR: result=in_pcplus, target=(in_rs1+in_op2)&~1.
//    BEQ/BNE/BLT/BGE/BLTU/BGEU compare in_rs1 vs in_op2, target=in_pc+in_imm, out_wr_reg=0.
//    CSRR/CSRW pass in_rs1 through as result; out_wr_reg per rd as for ALU ops.
//  - br_clear: combinational, =1 in the same cycle a valid taken branch/JAL/JALR is at the input
//    and stall_out=0; the branch itself still enters the output latch at that edge.
//  - in_valid=0 or in_op=INVALID_I: output latch loads a bubble (out_valid=0, all fields 0).
//  - out_wr_reg = in_valid & writes-rd(op) & (in_rd!=0); SW and branches never write.
//  - MUL FSM: IDLE -> BUSY -> DONE -> IDLE.
//    IDLE: valid MUL at input -> capture rs1/op2 into multiplicand/multiplier regs, acc=0, cnt=0,
//          go BUSY; stall_out=1 this cycle; output latch loads bubble.
//    BUSY: each cycle acc += multiplicand*multiplier[MUL_BITS-1:0] (shifted), multiplier >>= MUL_BITS,
//          multiplicand <<= MUL_BITS, cnt++; stall_out=1; latch loads bubble;
//          cnt==MUL_ITERS-1 -> DONE.
//    DONE: stall_out=0; latch loads MUL with out_result = low 32 bits of product; -> IDLE.
//    Total: input held MUL_ITERS+2 cycles (10 at default); in_* ignored while BUSY.
//  - br_clear is never asserted while FSM != IDLE.
//  - Reset asserted mid-MUL aborts the operation; no result is produced.
// TESTING
//  1 ADDI in_rs1=5, in_op2=-3, rd=7 -> next cycle out_valid=1, out_result=2, out_wr_reg=1, stall_out=0.
//  2 BEQ rs1=op2=9, pc=0x100, imm=0x20 -> same cycle br_clear=1, br_target=0x120; latched out_wr_reg=0.
//    BNE with same operands -> br_clear=0.
//  3 MUL 0xFFFFFFFF*3, rd=4, held -> stall_out=1 for 9 cycles, then out_result=0xFFFFFFFD,
//    out_valid=1 for exactly one cycle.
//  4 JALR rs1=0x203, op2=4, pcplus=0x44 -> br_target=0x206, out_result=0x44.
//  5 ADD with rd=0 -> out_valid=1, out_wr_reg=0; SLT -1<1 -> 1, SLTU 0xFFFFFFFF<1 -> 0; SRA 0x80000000>>4 -> 0xF8000000.
//  6 reset low at 4th BUSY cycle of MUL -> outputs 0 immediately, FSM IDLE; after release, ADD executes in 1 cycle.

Source files
------------

// File: rtl/agex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | agex_stage: execute / address-generation stage with an iterative          |
// | shift-add multiplier and combinational branch resolution.                  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+

package agex_pkg;
  localparam int IOPBITS = 6;
  localparam logic [IOPBITS-1:0]
    ADD_I   = 6'd0,  SUB_I   = 6'd1,  AND_I   = 6'd2,  OR_I    = 6'd3,
    XOR_I   = 6'd4,  SLL_I   = 6'd5,  SRL_I   = 6'd6,  SRA_I   = 6'd7,
    SLT_I   = 6'd8,  SLTU_I  = 6'd9,  ADDI_I  = 6'd10, ANDI_I  = 6'd11,
    ORI_I   = 6'd12, XORI_I  = 6'd13, SLLI_I  = 6'd14, SRLI_I  = 6'd15,
    SRAI_I  = 6'd16, SLTI_I  = 6'd17, SLTIU_I = 6'd18, LUI_I   = 6'd19,
    AUIPC_I = 6'd20, LW_I    = 6'd21, SW_I    = 6'd22, JAL_I   = 6'd23,
    JALR_I  = 6'd24, BEQ_I   = 6'd25, BNE_I   = 6'd26, BLT_I   = 6'd27,
    BGE_I   = 6'd28, BLTU_I  = 6'd29, BGEU_I  = 6'd30, MUL_I   = 6'd31,
    CSRR_I  = 6'd32, CSRW_I  = 6'd33, INVALID_I = 6'd34;
endpackage

module agex_stage
  import agex_pkg::*;
#(
  parameter int MUL_BITS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [IOPBITS-1:0] in_op,
  input  logic [31:0]        in_pc,
  input  logic [31:0]        in_pcplus,
  input  logic [31:0]        in_rs1,
  input  logic [31:0]        in_op2,
  input  logic [31:0]        in_imm,
  input  logic [4:0]         in_rd,
  output logic               stall_out,
  output logic               br_clear,
  output logic [31:0]        br_target,
  output logic               out_valid,
  output logic [IOPBITS-1:0] out_op,
  output logic [4:0]         out_rd,
  output logic               out_wr_reg,
  output logic [31:0]        out_result,
  output logic [31:0]        out_wdata
);
  localparam int MUL_ITERS = 32 / MUL_BITS;
  localparam int CNT_W = (MUL_ITERS > 1) ? $clog2(MUL_ITERS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITERS - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [31:0]        mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_valid_q, out_valid_d, out_wr_reg_q, out_wr_reg_d;
  logic [IOPBITS-1:0] out_op_q, out_op_d;
  logic [4:0]         out_rd_q, out_rd_d;
  logic [31:0]        out_result_q, out_result_d, out_wdata_q, out_wdata_d;

  logic [31:0] alu_res, target, jalr_sum, digit;
  logic        known, writes_rd, taken, is_mul;

  always_comb begin
    alu_res   = '0;
    known     = 1'b1;
    writes_rd = 1'b1;
    taken     = 1'b0;
    target    = in_pc + in_imm;
    jalr_sum  = in_rs1 + in_op2;
    case (in_op)
      ADD_I, ADDI_I, LW_I: alu_res = in_rs1 + in_op2;
      SUB_I:               alu_res = in_rs1 - in_op2;
      AND_I, ANDI_I:       alu_res = in_rs1 & in_op2;
      OR_I, ORI_I:         alu_res = in_rs1 | in_op2;
      XOR_I, XORI_I:       alu_res = in_rs1 ^ in_op2;
      SLL_I, SLLI_I:       alu_res = in_rs1 << in_op2[4:0];
      SRL_I, SRLI_I:       alu_res = in_rs1 >> in_op2[4:0];
      SRA_I, SRAI_I:       alu_res = $signed(in_rs1) >>> in_op2[4:0];
      SLT_I, SLTI_I:       alu_res = {31'b0, $signed(in_rs1) < $signed(in_op2)};
      SLTU_I, SLTIU_I:     alu_res = {31'b0, in_rs1 < in_op2};
      LUI_I:               alu_res = in_op2;
      AUIPC_I:             alu_res = in_pc + in_op2;
      SW_I: begin
        alu_res   = in_rs1 + in_imm;
        writes_rd = 1'b0;
      end
      JAL_I: begin
        alu_res = in_pcplus;
        taken   = 1'b1;
        target  = in_pc + in_op2;
      end
      JALR_I: begin
        alu_res = in_pcplus;
        taken   = 1'b1;
        target  = {jalr_sum[31:1], 1'b0};
      end
      BEQ_I:  begin writes_rd = 1'b0; taken = (in_rs1 == in_op2); end
      BNE_I:  begin writes_rd = 1'b0; taken = (in_rs1 != in_op2); end
      BLT_I:  begin writes_rd = 1'b0; taken = ($signed(in_rs1) <  $signed(in_op2)); end
      BGE_I:  begin writes_rd = 1'b0; taken = ($signed(in_rs1) >= $signed(in_op2)); end
      BLTU_I: begin writes_rd = 1'b0; taken = (in_rs1 <  in_op2); end
      BGEU_I: begin writes_rd = 1'b0; taken = (in_rs1 >= in_op2); end
      MUL_I:  alu_res = '0;
      CSRR_I, CSRW_I: alu_res = in_rs1;
      default: begin
        known     = 1'b0;
        writes_rd = 1'b0;
      end
    endcase
  end

  assign is_mul = in_valid && (in_op == MUL_I);

  // Combinational handshakes are forced low while reset is held so an aborted MUL goes quiet at once.
  assign stall_out = reset && (((state_q == S_IDLE) && is_mul) || (state_q == S_BUSY));
  assign br_clear  = reset && (state_q == S_IDLE) && in_valid && taken;
  assign br_target = target;

  always_comb begin
    state_d      = state_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    out_valid_d  = 1'b0;
    out_op_d     = '0;
    out_rd_d     = '0;
    out_wr_reg_d = 1'b0;
    out_result_d = '0;
    out_wdata_d  = '0;
    digit        = '0;
    digit[MUL_BITS-1:0] = mplier_q[MUL_BITS-1:0];
    case (state_q)
      S_IDLE: begin
        if (is_mul) begin
          mcand_d  = in_rs1;
          mplier_d = in_op2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_BUSY;
        end else if (in_valid && known) begin
          out_valid_d  = 1'b1;
          out_op_d     = in_op;
          out_rd_d     = in_rd;
          out_wr_reg_d = writes_rd && (in_rd != 5'd0);
          out_result_d = alu_res;
          out_wdata_d  = (in_op == SW_I) ? in_op2 : 32'd0;
        end
      end
      S_BUSY: begin
        acc_d    = acc_q + mcand_q * digit;
        mplier_d = mplier_q >> MUL_BITS;
        mcand_d  = mcand_q << MUL_BITS;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = S_DONE;
      end
      S_DONE: begin
        out_valid_d  = 1'b1;
        out_op_d     = MUL_I;
        out_rd_d     = in_rd;
        out_wr_reg_d = (in_rd != 5'd0);
        out_result_d = acc_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      mcand_q      <= '0;
      mplier_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_op_q     <= '0;
      out_rd_q     <= '0;
      out_wr_reg_q <= 1'b0;
      out_result_q <= '0;
      out_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_op_q     <= out_op_d;
      out_rd_q     <= out_rd_d;
      out_wr_reg_q <= out_wr_reg_d;
      out_result_q <= out_result_d;
      out_wdata_q  <= out_wdata_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_op     = out_op_q;
  assign out_rd     = out_rd_q;
  assign out_wr_reg = out_wr_reg_q;
  assign out_result = out_result_q;
  assign out_wdata  = out_wdata_q;
endmodule

`default_nettype wire

// File: tb/tb_agex_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_agex_stage: directed and randomized checks of agex_stage.              |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_agex_stage;
  import agex_pkg::*;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic [IOPBITS-1:0] in_op;
  logic [31:0]        in_pc, in_pcplus, in_rs1, in_op2, in_imm;
  logic [4:0]         in_rd;
  logic               stall_out, br_clear, out_valid, out_wr_reg;
  logic [31:0]        br_target, out_result, out_wdata;
  logic [IOPBITS-1:0] out_op;
  logic [4:0]         out_rd;

  int checks = 0;
  int errors = 0;

  agex_stage #(.MUL_BITS(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_op(in_op), .in_pc(in_pc),
    .in_pcplus(in_pcplus), .in_rs1(in_rs1), .in_op2(in_op2), .in_imm(in_imm),
    .in_rd(in_rd), .stall_out(stall_out), .br_clear(br_clear), .br_target(br_target),
    .out_valid(out_valid), .out_op(out_op), .out_rd(out_rd), .out_wr_reg(out_wr_reg),
    .out_result(out_result), .out_wdata(out_wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference semantics written as plain integer arithmetic on 64-bit values.
  task automatic model(input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                       output logic [31:0] res, output logic [31:0] tgt,
                       output bit wr, output bit known, output bit taken);
    longint sa, sb, ua, ub, p, q;
    logic [31:0] s;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'(a);          ub = longint'(b);
    p  = longint'(1) << b[4:0];
    res = 0; tgt = pc + imm; wr = 1; known = 1; taken = 0;
    case (op)
      ADD_I, ADDI_I, LW_I: res = 32'(ua + ub);
      SUB_I:           res = 32'(ua - ub);
      AND_I, ANDI_I:   res = a & b;
      OR_I, ORI_I:     res = a | b;
      XOR_I, XORI_I:   res = a ^ b;
      SLL_I, SLLI_I:   res = 32'(ua * p);
      SRL_I, SRLI_I:   res = 32'(ua / p);
      SRA_I, SRAI_I: begin
        q = (sa >= 0) ? sa / p : -((-sa + p - 1) / p);
        res = 32'(q);
      end
      SLT_I, SLTI_I:   res = (sa < sb) ? 32'd1 : 32'd0;
      SLTU_I, SLTIU_I: res = (ua < ub) ? 32'd1 : 32'd0;
      LUI_I:           res = b;
      AUIPC_I:         res = 32'(longint'(pc) + ub);
      SW_I:   begin res = 32'(ua + longint'(imm)); wr = 0; end
      JAL_I:  begin res = pc + 32'd4; taken = 1; tgt = pc + b; end
      JALR_I: begin res = pc + 32'd4; taken = 1; s = a + b; tgt = s - (s % 2); end
      BEQ_I:  begin wr = 0; taken = (ua == ub); end
      BNE_I:  begin wr = 0; taken = (ua != ub); end
      BLT_I:  begin wr = 0; taken = (sa <  sb); end
      BGE_I:  begin wr = 0; taken = (sa >= sb); end
      BLTU_I: begin wr = 0; taken = (ua <  ub); end
      BGEU_I: begin wr = 0; taken = (ua >= ub); end
      CSRR_I, CSRW_I: res = a;
      default: begin known = 0; wr = 0; end
    endcase
  endtask

  // Called between edges; applies one single-cycle op and checks both sides of the edge.
  task automatic run_op(input string tag, input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                        input logic [4:0] rd, input bit v);
    logic [31:0] eres, etgt;
    bit ewr, eknown, etaken, live;
    model(op, a, b, imm, pc, eres, etgt, ewr, eknown, etaken);
    live = v && eknown;
    in_valid = v; in_op = op; in_rs1 = a; in_op2 = b; in_imm = imm;
    in_pc = pc; in_pcplus = pc + 32'd4; in_rd = rd;
    #1;
    chk({tag, "_stall"}, 32'(stall_out), 32'd0);
    chk({tag, "_brclr"}, 32'(br_clear), 32'(v && etaken));
    if (v && etaken) chk({tag, "_tgt"}, br_target, etgt);
    @(posedge clk); #1;
    chk({tag, "_oval"}, 32'(out_valid), 32'(live));
    chk({tag, "_oop"},  32'(out_op),    live ? 32'(op) : 32'd0);
    chk({tag, "_ord"},  32'(out_rd),    live ? 32'(rd) : 32'd0);
    chk({tag, "_owr"},  32'(out_wr_reg), 32'(live && ewr && rd != 5'd0));
    chk({tag, "_ores"}, out_result,     live ? eres : 32'd0);
    chk({tag, "_owd"},  out_wdata,      (live && op == SW_I) ? b : 32'd0);
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, b, input logic [4:0] rd);
    logic [63:0] prod;
    int stalls, bad;
    bit done;
    prod = {32'd0, a} * {32'd0, b};
    stalls = 0; bad = 0; done = 0;
    in_valid = 1; in_op = MUL_I; in_rs1 = a; in_op2 = b; in_imm = 0; in_rd = rd;
    #1;
    for (int k = 0; k < 20 && !done; k++) begin
      if (stall_out === 1'b1) begin
        stalls++;
        if (k > 0 && out_valid !== 1'b0) bad++;
        @(posedge clk); #1;
      end else begin
        done = 1;
      end
    end
    chk({tag, "_stalls"}, 32'(stalls), 32'd9);
    chk({tag, "_bubbles"}, 32'(bad), 32'd0);
    chk({tag, "_brclr"}, 32'(br_clear), 32'd0);
    @(posedge clk); #1;
    in_valid = 0;
    chk({tag, "_oval"}, 32'(out_valid), 32'd1);
    chk({tag, "_oop"},  32'(out_op), 32'(MUL_I));
    chk({tag, "_ord"},  32'(out_rd), 32'(rd));
    chk({tag, "_owr"},  32'(out_wr_reg), 32'(rd != 5'd0));
    chk({tag, "_ores"}, out_result, prod[31:0]);
    chk({tag, "_owd"},  out_wdata, 32'd0);
    @(posedge clk); #1;
    chk({tag, "_once"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  rop;
    logic [31:0] ra, rb;
    reset = 1; in_valid = 0; in_op = '0; in_pc = 0; in_pcplus = 0;
    in_rs1 = 0; in_op2 = 0; in_imm = 0; in_rd = 0;
    #1 reset = 0;
    #1;
    chk("rst_oval", 32'(out_valid), 32'd0);
    chk("rst_ores", out_result, 32'd0);
    chk("rst_owr",  32'(out_wr_reg), 32'd0);
    chk("rst_stall", 32'(stall_out), 32'd0);
    chk("rst_brclr", 32'(br_clear), 32'd0);
    #20;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;

    run_op("addi", ADDI_I, 32'd5, 32'hFFFF_FFFD, 0, 32'h40, 5'd7, 1);
    run_op("beq",  BEQ_I, 32'd9, 32'd9, 32'h20, 32'h100, 5'd3, 1);
    run_op("bne",  BNE_I, 32'd9, 32'd9, 32'h20, 32'h100, 5'd3, 1);
    run_mul("mul", 32'hFFFF_FFFF, 32'd3, 5'd4);
    run_op("jalr", JALR_I, 32'h203, 32'd4, 0, 32'h40, 5'd1, 1);
    run_op("add_rd0", ADD_I, 32'd1, 32'd2, 0, 0, 5'd0, 1);
    run_op("slt",  SLT_I,  32'hFFFF_FFFF, 32'd1, 0, 0, 5'd2, 1);
    run_op("sltu", SLTU_I, 32'hFFFF_FFFF, 32'd1, 0, 0, 5'd2, 1);
    run_op("sra",  SRA_I,  32'h8000_0000, 32'd4, 0, 0, 5'd2, 1);
    run_op("sw",   SW_I,   32'h1000, 32'hDEAD_BEEF, 32'h8, 0, 5'd9, 1);
    run_op("inval", INVALID_I, 32'd1, 32'd1, 0, 0, 5'd5, 1);
    run_op("bubble", ADD_I, 32'd1, 32'd1, 0, 0, 5'd5, 0);

    // Abort a multiply with reset during its fourth busy cycle.
    in_valid = 1; in_op = MUL_I; in_rs1 = 32'd7; in_op2 = 32'd6; in_rd = 5'd4;
    repeat (4) @(posedge clk);
    #2 reset = 0;
    #1;
    chk("abort_stall", 32'(stall_out), 32'd0);
    chk("abort_brclr", 32'(br_clear), 32'd0);
    chk("abort_oval",  32'(out_valid), 32'd0);
    chk("abort_ores",  out_result, 32'd0);
    in_valid = 0;
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    chk("abort_idle_stall", 32'(stall_out), 32'd0);
    chk("abort_noresult", 32'(out_valid), 32'd0);
    run_op("post_rst_add", ADD_I, 32'd10, 32'd20, 0, 0, 5'd6, 1);

    for (int i = 0; i < 150; i++) begin
      rop = 6'($urandom_range(0, 35));
      if (rop == MUL_I) rop = ADD_I;
      if (rop == 6'd35) rop = 6'd63;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      run_op("rnd", rop, ra, rb, $urandom, $urandom, 5'($urandom_range(0, 31)),
             $urandom_range(0, 9) != 0);
    end
    for (int i = 0; i < 4; i++) begin
      run_mul("rnd_mul", $urandom, $urandom, 5'($urandom_range(0, 31)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
